lcd_frame_scheduler: RTL
========================

Name: lcd_frame_scheduler

Overview:
- Sequences full-window pixel streams into the ILI9341 LT24 pixel-write port (print/done/en handshake).
- Arbitrates two requesters: a clear request, which fills the window with a constant colour, and a refresh request, which streams the framebuffer RAM at 1-cycle read latency.
- Sits between the canvas/inference logic and the LCD driver. It issues pixels in raster order into the window the driver opened after initialisation.

Parameters:
- H_RES, 160, window width in pixels.
- V_RES, 144, window height in pixels.
- ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.

Ports:
- clk  in  1  system clock, at most 30 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- clear_req  in  1  one-cycle pulse: request a clear frame.
- clear_color  in  16  RGB565 fill colour, sampled at clear frame start.
- refresh_req  in  1  one-cycle pulse: request a framebuffer frame.
- fb_rd_en  out  1  framebuffer read strobe.
- fb_rd_addr  out  ADDR_W  framebuffer read address (linear, y*H_RES+x).
- fb_rd_data  in  16  RGB565 pixel, valid the cycle after fb_rd_en.
- lcd_initialized  in  1  driver initialisation complete.
- lcd_done  in  1  driver pixel-write complete.
- lcd_en  out  1  driver enable.
- lcd_print  out  1  driver pixel strobe.
- lcd_pixel_rgb  out  16  pixel to driver.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse: frame completed.
- pixel_x  out  8  current column.
- pixel_y  out  8  current row.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Outputs: all outputs 0. lcd_pixel_rgb=0, fb_rd_addr=0, pixel_x=0, pixel_y=0.
  - Internal: pending_clear=0, pending_refresh=0, state=WAIT_INIT.
- Pending flags:
  - clear_req sets pending_clear; refresh_req sets pending_refresh. Both are sticky.
  - A flag clears on the cycle its frame starts.
  - A request arriving during a frame of the same type re-arms the flag, so the frame runs again.
- States:
  - WAIT_INIT: outputs idle. Go to IDLE when lcd_initialized=1.
  - IDLE: busy=0.
    - pending_clear → CLEAR start: latch clear_color, counters=0, go to ISSUE.
    - else pending_refresh → REFRESH start: counters=0, go to FETCH.
    - Clear has strict priority. If both flags are set, clear runs first, then refresh.
  - FETCH (refresh only): fb_rd_en=1, fb_rd_addr=linear counter. Next state LATCH.
  - LATCH: lcd_pixel_rgb<=fb_rd_data. Next state ISSUE.
  - ISSUE: lcd_print=1, lcd_pixel_rgb held stable. Next state HOLD.
  - HOLD: lcd_print=1. Next state RELEASE.
  - RELEASE: lcd_print=0. Wait for lcd_done=1, then act on the pixel position:
    - Last pixel (x=H_RES-1, y=V_RES-1): go to DONE.
    - Otherwise increment x. At x=H_RES-1, x wraps to 0 and y increments.
    - Next state is FETCH (refresh) or ISSUE (clear).
  - DONE: frame_done=1 for exactly one cycle. Next state IDLE.
- Per-pixel cost: clear 3 cycles/pixel, refresh 5 cycles/pixel (with lcd_done already high).
- lcd_en=1 and busy=1 in every state except WAIT_INIT and IDLE.
- Stability: lcd_pixel_rgb is stable from ISSUE through RELEASE. Clear frames use the latched colour, so clear_color changes mid-frame have no effect.
- Linear counter: 0..H_RES*V_RES-1. No wrap beyond the last pixel.
- Abort: lcd_initialized falling in any state except WAIT_INIT:
  - Next cycle goes to WAIT_INIT. lcd_print=0, lcd_en=0, counters=0, no frame_done.
  - The aborted frame's type flag is re-set, so the frame restarts from pixel 0 after re-init.
- Simultaneous events: a request on the same cycle its flag is being cleared (frame start) leaves the flag set.

Test Plan:
- Clear after init (H_RES=4, V_RES=3): reset, raise lcd_initialized, clear_req with clear_color=16'hF800, lcd_done tied 1.
  → 12 pixels at 16'hF800, each with lcd_print high 2 cycles. frame_done 37 cycles after leaving IDLE. busy low after.
- Refresh streaming: fb model returns addr+16'h100.
  → fb_rd_addr 0..11 in order, lcd_pixel_rgb 16'h100..16'h10B. pixel_x/pixel_y wrap at x=3. One frame_done.
- Priority: clear_req and refresh_req on the same cycle in IDLE.
  → clear frame fully first, then refresh frame. Two frame_done pulses.
- Handshake stall: hold lcd_done=0 for 10 cycles in RELEASE at pixel 5.
  → counters frozen, lcd_print=0, lcd_pixel_rgb unchanged. Resumes at pixel 6.
- Abort: drop lcd_initialized at pixel 7 of a refresh.
  → WAIT_INIT next cycle, outputs 0, no frame_done. After re-init the refresh restarts from fb_rd_addr=0.
- Async reset mid-frame: assert reset_n=0 between clock edges.
  → all outputs 0 immediately. Pending flags cleared. Returns to WAIT_INIT.

Source files
------------

// File: rtl/lcd_frame_scheduler.sv
// lcd_frame_scheduler: feeds full-window pixel streams into the LT24 pixel-write
// port. Arbitrates a constant-colour clear frame against a framebuffer refresh
// frame and walks the window in raster order, one print/done handshake per pixel.
module lcd_frame_scheduler #(
   parameter int H_RES  = 160,
   parameter int V_RES  = 144,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear_req,
   input  logic [15:0]       clear_color,
   input  logic              refresh_req,
   output logic              fb_rd_en,
   output logic [ADDR_W-1:0] fb_rd_addr,
   input  logic [15:0]       fb_rd_data,
   input  logic              lcd_initialized,
   input  logic              lcd_done,
   output logic              lcd_en,
   output logic              lcd_print,
   output logic [15:0]       lcd_pixel_rgb,
   output logic              busy,
   output logic              frame_done,
   output logic [7:0]        pixel_x,
   output logic [7:0]        pixel_y
);

   localparam logic [7:0] X_LAST = 8'(H_RES - 1);
   localparam logic [7:0] Y_LAST = 8'(V_RES - 1);

   typedef enum logic [2:0] {
      WAIT_INIT,
      IDLE,
      FETCH,
      LATCH,
      ISSUE,
      HOLD,
      RELEASE,
      DONE
   } state_t;

   state_t            state;
   logic              pending_clear;
   logic              pending_refresh;
   logic              frame_refresh;
   logic [ADDR_W-1:0] lin_cnt;

   logic abort;
   logic in_frame;
   logic start_clear;
   logic start_refresh;
   logic rearm_clear;
   logic rearm_refresh;
   logic last_pixel;

   // Frame start, abort and end-of-window decode shared by the flag and FSM registers
   always_comb begin
      abort         = 1'b0;
      in_frame      = 1'b0;
      start_clear   = 1'b0;
      start_refresh = 1'b0;
      rearm_clear   = 1'b0;
      rearm_refresh = 1'b0;
      last_pixel    = 1'b0;
      abort         = (state != WAIT_INIT) && !lcd_initialized;
      in_frame      = state inside {FETCH, LATCH, ISSUE, HOLD, RELEASE};
      start_clear   = (state == IDLE) && lcd_initialized && pending_clear;
      start_refresh = (state == IDLE) && lcd_initialized && !pending_clear && pending_refresh;
      rearm_clear   = abort && in_frame && !frame_refresh;
      rearm_refresh = abort && in_frame && frame_refresh;
      last_pixel    = (pixel_x == X_LAST) && (pixel_y == Y_LAST);
   end

   // Sticky request flags: a new request always wins over the start-of-frame clear,
   // and an aborted frame re-arms its own flag so it restarts after re-init
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_clear   <= 1'b0;
         pending_refresh <= 1'b0;
      end else begin
         pending_clear   <= clear_req   | rearm_clear   | (pending_clear   & ~start_clear);
         pending_refresh <= refresh_req | rearm_refresh | (pending_refresh & ~start_refresh);
      end
   end

   // Frame sequencer with registered handshake, framebuffer and position outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= WAIT_INIT;
         frame_refresh <= 1'b0;
         lin_cnt       <= '0;
         fb_rd_en      <= 1'b0;
         fb_rd_addr    <= '0;
         lcd_en        <= 1'b0;
         lcd_print     <= 1'b0;
         lcd_pixel_rgb <= '0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         pixel_x       <= '0;
         pixel_y       <= '0;
      end else if (abort) begin
         state         <= WAIT_INIT;
         frame_refresh <= 1'b0;
         lin_cnt       <= '0;
         fb_rd_en      <= 1'b0;
         fb_rd_addr    <= '0;
         lcd_en        <= 1'b0;
         lcd_print     <= 1'b0;
         lcd_pixel_rgb <= '0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         pixel_x       <= '0;
         pixel_y       <= '0;
      end else begin
         case (state)
            WAIT_INIT: begin
               if (lcd_initialized) state <= IDLE;
            end
            IDLE: begin
               if (start_clear) begin
                  // The output register doubles as the colour latch for the whole frame
                  frame_refresh <= 1'b0;
                  lcd_pixel_rgb <= clear_color;
                  lin_cnt       <= '0;
                  pixel_x       <= '0;
                  pixel_y       <= '0;
                  busy          <= 1'b1;
                  lcd_en        <= 1'b1;
                  lcd_print     <= 1'b1;
                  state         <= ISSUE;
               end else if (start_refresh) begin
                  frame_refresh <= 1'b1;
                  lin_cnt       <= '0;
                  pixel_x       <= '0;
                  pixel_y       <= '0;
                  fb_rd_en      <= 1'b1;
                  fb_rd_addr    <= '0;
                  busy          <= 1'b1;
                  lcd_en        <= 1'b1;
                  state         <= FETCH;
               end
            end
            FETCH: begin
               fb_rd_en <= 1'b0;
               state    <= LATCH;
            end
            LATCH: begin
               lcd_pixel_rgb <= fb_rd_data;
               lcd_print     <= 1'b1;
               state         <= ISSUE;
            end
            ISSUE: begin
               state <= HOLD;
            end
            HOLD: begin
               lcd_print <= 1'b0;
               state     <= RELEASE;
            end
            RELEASE: begin
               if (lcd_done) begin
                  if (last_pixel) begin
                     frame_done <= 1'b1;
                     state      <= DONE;
                  end else begin
                     lin_cnt <= lin_cnt + ADDR_W'(1);
                     if (pixel_x == X_LAST) begin
                        pixel_x <= '0;
                        pixel_y <= pixel_y + 8'd1;
                     end else begin
                        pixel_x <= pixel_x + 8'd1;
                     end
                     if (frame_refresh) begin
                        fb_rd_en   <= 1'b1;
                        fb_rd_addr <= lin_cnt + ADDR_W'(1);
                        state      <= FETCH;
                     end else begin
                        lcd_print <= 1'b1;
                        state     <= ISSUE;
                     end
                  end
               end
            end
            DONE: begin
               frame_done <= 1'b0;
               busy       <= 1'b0;
               lcd_en     <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
